// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the multi-cycle MIPS datapath.
// Optional build macro MC_MEM_WAIT_EN: FETCH, MEMRD and MEMWR hold until mem_ready.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        IorD,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALU_Control,
  output logic [1:0]  PCSrc,
  output logic        PCEn,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  logic [3:0] r_state, w_next;
  logic [5:0] w_op, w_fn;
  logic       w_rdy, w_pcwrite, w_branch, w_unused;

  assign w_op = Instr[31:26];
  assign w_fn = Instr[5:0];

`ifdef MC_MEM_WAIT_EN
  assign w_rdy    = mem_ready;
  assign w_unused = ^Instr[25:6];
`else
  // memory always completes in one cycle; mem_ready is not looked at
  assign w_rdy    = 1'b1;
  assign w_unused = ^{Instr[25:6], mem_ready};
`endif

  // state register; reset abandons the current instruction and returns to FETCH at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  // per-state datapath controls and next state, with IR decode in DECODE/EXECUTE
  always_comb begin
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_Control = 3'b010;
    PCSrc       = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_next      = FETCH;
    case (r_state)
      FETCH: begin
        ALUSrcB   = 2'b01;
        IRWrite   = w_rdy;
        w_pcwrite = w_rdy;
        w_next    = w_rdy ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        if (w_op == 6'b100011 || w_op == 6'b101011) w_next = MEMADR;
        else if (w_op == 6'b000000) w_next = EXECUTE;
        else if (w_op == 6'b000100) w_next = BRANCH;
        else if (w_op == 6'b001000) w_next = ADDIEXEC;
        else if (w_op == 6'b000010) w_next = JUMP;
        else illegal = 1'b1;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (w_op == 6'b101011) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD   = 1'b1;
        w_next = w_rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = w_rdy;
        w_next     = w_rdy ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        case (w_fn)
          6'b100000: w_next = ALUWB;
          6'b100010: begin ALU_Control = 3'b110; w_next = ALUWB; end
          6'b100100: begin ALU_Control = 3'b000; w_next = ALUWB; end
          6'b100101: begin ALU_Control = 3'b001; w_next = ALUWB; end
          6'b101010: begin ALU_Control = 3'b111; w_next = ALUWB; end
          default:   illegal = 1'b1;
        endcase
      end
      ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_Control = 3'b110;
        w_branch    = 1'b1;
        PCSrc       = 2'b01;
        instr_done  = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = ADDIWB;
      end
      ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        w_pcwrite  = 1'b1;
        instr_done = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  assign PCEn  = w_pcwrite | (w_branch & zero);
  assign state = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level model of expected per-cycle controls, checked every cycle.
module tb_multicycle_ctrl;
  logic        clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, instr_done, illegal;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALU_Control;
  logic [3:0]  state;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .Instr(Instr), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALU_Control(ALU_Control), .PCSrc(PCSrc), .PCEn(PCEn), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [20:0] v; logic mr;} ent_t;
  ent_t        q[$];
  string       cur = "idle";
  int          n_chk = 0, n_fail = 0;
  logic [20:0] dv;

  assign dv = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALU_Control, PCSrc, PCEn, instr_done, illegal, state};

  // flags = {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA}, tl = {PCEn,instr_done,illegal}
  function automatic logic [20:0] w(input logic [3:0] st, input logic [6:0] flags, input logic [1:0] sb,
                                    input logic [2:0] alu, input logic [1:0] ps, input logic [2:0] tl);
    return {flags, sb, alu, ps, tl, st};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic push(input logic [20:0] v, input logic mr);
    ent_t e;
    e.v = v;
    e.mr = mr;
    q.push_back(e);
  endtask

  // a memory state: stall cycles (hold value) only when waits are built in, then the completing cycle
  task automatic mem(input logic [20:0] hv, input logic [20:0] rv, input int stall, input logic lmr);
`ifdef MC_MEM_WAIT_EN
    for (int i = 0; i < stall; i++) push(hv, 1'b0);
`else
    if (hv != rv) push(rv, lmr); else push(rv, lmr);
    return;
`endif
    push(rv, lmr);
  endtask

  // issue one instruction starting in FETCH; cut>0 stops after that many cycles
  task automatic run(input logic [31:0] ins, input logic z, input int stall, input int cpi, input int cut, input string nm);
    logic [5:0] op, fn;
    logic [2:0] alu;
    logic       ok, fok, lmr;
    int         extra, k;
    op = ins[31:26];
    fn = ins[5:0];
    lmr = (stall == 0);
    extra = 0;
`ifdef MC_MEM_WAIT_EN
    lmr = 1'b1;
    if (op == 6'b100011 || op == 6'b101011) extra = stall;
`endif
    cur = nm;
    Instr = ins;
    zero = z;
    push(w(4'd0, 7'b0010000, 2'b01, 3'b010, 2'b00, 3'b100), lmr);
    ok = op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    push(w(4'd1, 7'b0000000, 2'b11, 3'b010, 2'b00, {2'b00, !ok}), lmr);
    if (op == 6'b100011) begin
      push(w(4'd2, 7'b0000001, 2'b10, 3'b010, 2'b00, 3'b000), lmr);
      mem(w(4'd3, 7'b1000000, 2'b00, 3'b010, 2'b00, 3'b000), w(4'd3, 7'b1000000, 2'b00, 3'b010, 2'b00, 3'b000), stall, lmr);
      push(w(4'd4, 7'b0000110, 2'b00, 3'b010, 2'b00, 3'b010), lmr);
    end else if (op == 6'b101011) begin
      push(w(4'd2, 7'b0000001, 2'b10, 3'b010, 2'b00, 3'b000), lmr);
      mem(w(4'd5, 7'b1100000, 2'b00, 3'b010, 2'b00, 3'b000), w(4'd5, 7'b1100000, 2'b00, 3'b010, 2'b00, 3'b010), stall, lmr);
    end else if (op == 6'b000000) begin
      fok = 1'b1;
      case (fn)
        6'b100000: alu = 3'b010;
        6'b100010: alu = 3'b110;
        6'b100100: alu = 3'b000;
        6'b100101: alu = 3'b001;
        6'b101010: alu = 3'b111;
        default: begin alu = 3'b010; fok = 1'b0; end
      endcase
      push(w(4'd6, 7'b0000001, 2'b00, alu, 2'b00, {2'b00, !fok}), lmr);
      if (fok) push(w(4'd7, 7'b0001010, 2'b00, 3'b010, 2'b00, 3'b010), lmr);
    end else if (op == 6'b000100) begin
      push(w(4'd8, 7'b0000001, 2'b00, 3'b110, 2'b01, {z, 2'b10}), lmr);
    end else if (op == 6'b001000) begin
      push(w(4'd9, 7'b0000001, 2'b10, 3'b010, 2'b00, 3'b000), lmr);
      push(w(4'd10, 7'b0000010, 2'b00, 3'b010, 2'b00, 3'b010), lmr);
    end else if (op == 6'b000010) begin
      push(w(4'd11, 7'b0000000, 2'b00, 3'b010, 2'b10, 3'b110), lmr);
    end
    chk({nm, " cycles"}, 32'(q.size()), 32'(cpi + extra));
    k = 0;
    while (q.size() > 0 && (cut == 0 || k < cut)) begin
      mem_ready = q[0].mr;
      @(posedge clk);
      #1;
      k++;
    end
    if (cut != 0) q.delete();
    mem_ready = 1'b1;
  endtask

  // compare DUT against the model's entry for this cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      ent_t e;
      e = q.pop_front();
      chk($sformatf("%s st%0d", cur, e.v[3:0]), 32'(dv), 32'(e.v));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst state", 32'(state), 32'd0);
    chk("rst IRWrite", 32'(IRWrite), 32'd1);
    chk("rst PCEn", 32'(PCEn), 32'd1);
    chk("rst vector", 32'(dv), 32'(w(4'd0, 7'b0010000, 2'b01, 3'b010, 2'b00, 3'b100)));
    @(posedge clk);
    #1 rst = 1'b0;
    run(32'h8C430004, 1'b0, 0, 5, 0, "lw");
    run(32'hAC430008, 1'b1, 0, 4, 0, "sw");
    run(32'h00221820, 1'b0, 0, 4, 0, "add");
    run(32'h00221822, 1'b1, 0, 4, 0, "sub");
    run(32'h00221824, 1'b0, 0, 4, 0, "and");
    run(32'h00221825, 1'b0, 0, 4, 0, "or");
    run(32'h0022182A, 1'b0, 0, 4, 0, "slt");
    run(32'h00221807, 1'b0, 0, 3, 0, "bad_funct");
    run(32'h10220003, 1'b1, 0, 3, 0, "beq_taken");
    run(32'h10220003, 1'b0, 0, 3, 0, "beq_not");
    run(32'h20220005, 1'b1, 0, 4, 0, "addi");
    run(32'h08000010, 1'b0, 0, 3, 0, "j");
    run(32'hFC000000, 1'b1, 0, 2, 0, "bad_op");
    run(32'h8C430004, 1'b0, 0, 5, 3, "lw_cut");
    chk("pre-reset state", 32'(state), 32'd3);
    rst = 1'b1;
    #1;
    chk("async rst state", 32'(state), 32'd0);
    chk("async rst IRWrite", 32'(IRWrite), 32'd1);
    chk("async rst PCEn", 32'(PCEn), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    run(32'h8C430004, 1'b1, 0, 5, 0, "lw_after_rst");
    run(32'hAC430008, 1'b0, 3, 4, 0, "sw_wait");
    run(32'h8C430004, 1'b0, 2, 5, 0, "lw_wait");
    run(32'h00221822, 1'b0, 0, 4, 0, "sub_tail");
    chk("queue drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
